// File: rtl/legv8_sequencer.sv
// legv8_sequencer: multi-cycle control unit for the LEGv8 64-bit datapath.
// Takes one 32-bit instruction per valid/ready handshake and drives the
// datapath control word for one (R/I-type) or two (LDUR/STUR) execute cycles.
// It latches the ALU flags on ADDS/SUBS and pulses err on an illegal encoding.
// The control word is a pure function of the state register and the latched
// instruction register, so it can only change at a clock edge.
module legv8_sequencer #(
    parameter int unsigned RAM_AW = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [3:0]  STAT,
    output logic [4:0]  SA,
    output logic [4:0]  SB,
    output logic [4:0]  DA,
    output logic        WR,
    output logic [4:0]  FS,
    output logic        C0,
    output logic [63:0] K,
    output logic        M,
    output logic        EN_ALU,
    output logic        EN_B,
    output logic        EN_ADDR_ALU,
    output logic        RCS,
    output logic        RWE,
    output logic        ROE,
    output logic [3:0]  flags,
    output logic        done,
    output logic        err
);

    localparam int unsigned IR_W   = 32;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned FS_W   = 5;
    localparam int unsigned FLAG_W = 4;
    localparam int unsigned OFF_W  = 9;

    // ALU function-select codes
    localparam logic [FS_W-1:0] FS_AND = 5'b00000;
    localparam logic [FS_W-1:0] FS_ORR = 5'b00100;
    localparam logic [FS_W-1:0] FS_ADD = 5'b01000;
    localparam logic [FS_W-1:0] FS_SUB = 5'b01010;

    // R-type and D-type opcodes live in instr[31:21]
    localparam logic [10:0] OPC_ADD  = 11'b10001011000;
    localparam logic [10:0] OPC_SUB  = 11'b11001011000;
    localparam logic [10:0] OPC_AND  = 11'b10001010000;
    localparam logic [10:0] OPC_ORR  = 11'b10101010000;
    localparam logic [10:0] OPC_ADDS = 11'b10101011000;
    localparam logic [10:0] OPC_SUBS = 11'b11101011000;
    localparam logic [10:0] OPC_LDUR = 11'b11111000010;
    localparam logic [10:0] OPC_STUR = 11'b11111000000;
    // I-type opcodes live in instr[31:22]
    localparam logic [9:0]  OPC_ADDI = 10'b1001000100;
    localparam logic [9:0]  OPC_SUBI = 10'b1101000100;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXEC,
        ST_LD_A,
        ST_LD_W,
        ST_ST_A,
        ST_ST_W,
        ST_ERR
    } state_e;

    typedef enum logic [3:0] {
        OP_ADD,
        OP_SUB,
        OP_AND,
        OP_ORR,
        OP_ADDS,
        OP_SUBS,
        OP_ADDI,
        OP_SUBI,
        OP_LDUR,
        OP_STUR,
        OP_ILL
    } op_e;

    // Classify an instruction word; anything outside the table is illegal
    function automatic op_e decode_op(input logic [IR_W-1:0] w);
        op_e op;
        op = OP_ILL;
        case (w[31:21])
            OPC_ADD:  op = OP_ADD;
            OPC_SUB:  op = OP_SUB;
            OPC_AND:  op = OP_AND;
            OPC_ORR:  op = OP_ORR;
            OPC_ADDS: op = OP_ADDS;
            OPC_SUBS: op = OP_SUBS;
            OPC_LDUR: op = OP_LDUR;
            OPC_STUR: op = OP_STUR;
            default:  op = OP_ILL;
        endcase
        if (op == OP_ILL) begin
            case (w[31:22])
                OPC_ADDI: op = OP_ADDI;
                OPC_SUBI: op = OP_SUBI;
                default:  op = OP_ILL;
            endcase
        end
        return op;
    endfunction

    // The RAM address is carved out of the 64-bit ALU result
    if (RAM_AW < 1 || RAM_AW > DATA_W) begin : g_bad_ram_aw
        $error("legv8_sequencer: RAM_AW must lie in 1..64");
    end

    state_e              r_state;
    state_e              w_state_nxt;
    logic [IR_W-1:0]     r_ir;
    logic [FLAG_W-1:0]   r_flags;

    logic                w_accept;
    op_e                 w_in_op;
    op_e                 w_ir_op;
    logic                w_flag_upd;

    logic [REG_AW-1:0]   w_rd;
    logic [REG_AW-1:0]   w_rn;
    logic [REG_AW-1:0]   w_rm;
    logic [DATA_W-1:0]   w_imm_k;
    logic [DATA_W-1:0]   w_off_k;

    logic [FS_W-1:0]     w_ex_fs;
    logic                w_ex_c0;
    logic                w_ex_m;
    logic [DATA_W-1:0]   w_ex_k;
    logic [REG_AW-1:0]   w_ex_sb;

    // Handshake and decode of both the incoming and the latched word
    assign w_accept   = instr_valid && (r_state == ST_IDLE);
    assign w_in_op    = decode_op(instr);
    assign w_ir_op    = decode_op(r_ir);
    assign w_flag_upd = (r_state == ST_EXEC) &&
                        ((w_ir_op == OP_ADDS) || (w_ir_op == OP_SUBS));

    // Operand fields of the latched instruction; Rt shares the Rd slot
    assign w_rd    = r_ir[4:0];
    assign w_rn    = r_ir[9:5];
    assign w_rm    = r_ir[20:16];
    assign w_imm_k = DATA_W'(r_ir[21:10]);
    assign w_off_k = {{(DATA_W - OFF_W){r_ir[20]}}, r_ir[20:12]};

    // State register
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Instruction register, loaded only on an accepted handshake
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_ir <= '0;
        end else if (w_accept) begin
            r_ir <= instr;
        end
    end

    // ALU flags, captured at the edge that closes an ADDS/SUBS execute cycle
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_flags <= '0;
        end else if (w_flag_upd) begin
            r_flags <= STAT;
        end
    end

    assign flags = r_flags;

    // Next-state logic: dispatch from IDLE, fixed walk through execute states
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    case (w_in_op)
                        OP_LDUR: w_state_nxt = ST_LD_A;
                        OP_STUR: w_state_nxt = ST_ST_A;
                        OP_ILL:  w_state_nxt = ST_ERR;
                        default: w_state_nxt = ST_EXEC;
                    endcase
                end
            end
            ST_EXEC: w_state_nxt = ST_IDLE;
            ST_LD_A: w_state_nxt = ST_LD_W;
            ST_LD_W: w_state_nxt = ST_IDLE;
            ST_ST_A: w_state_nxt = ST_ST_W;
            ST_ST_W: w_state_nxt = ST_IDLE;
            ST_ERR:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ALU settings for the single-cycle R/I-type execute, keyed by opcode
    always_comb begin
        w_ex_fs = FS_ADD;
        w_ex_c0 = 1'b0;
        w_ex_m  = 1'b0;
        w_ex_k  = '0;
        w_ex_sb = w_rm;
        case (w_ir_op)
            OP_ADD, OP_ADDS: begin
                w_ex_fs = FS_ADD;
            end
            OP_SUB, OP_SUBS: begin
                w_ex_fs = FS_SUB;
                w_ex_c0 = 1'b1;
            end
            OP_AND: begin
                w_ex_fs = FS_AND;
            end
            OP_ORR: begin
                w_ex_fs = FS_ORR;
            end
            OP_ADDI: begin
                w_ex_fs = FS_ADD;
                w_ex_m  = 1'b1;
                w_ex_k  = w_imm_k;
                w_ex_sb = '0;
            end
            OP_SUBI: begin
                w_ex_fs = FS_SUB;
                w_ex_c0 = 1'b1;
                w_ex_m  = 1'b1;
                w_ex_k  = w_imm_k;
                w_ex_sb = '0;
            end
            default: begin
                w_ex_sb = '0;
            end
        endcase
    end

    // Control word per state; every field defaults to 0 (IDLE/ERR are quiet)
    always_comb begin
        instr_ready = 1'b0;
        SA          = '0;
        SB          = '0;
        DA          = '0;
        WR          = 1'b0;
        FS          = '0;
        C0          = 1'b0;
        K           = '0;
        M           = 1'b0;
        EN_ALU      = 1'b0;
        EN_B        = 1'b0;
        EN_ADDR_ALU = 1'b0;
        RCS         = 1'b0;
        RWE         = 1'b0;
        ROE         = 1'b0;
        done        = 1'b0;
        err         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                instr_ready = 1'b1;
            end
            ST_EXEC: begin
                SA     = w_rn;
                SB     = w_ex_sb;
                DA     = w_rd;
                FS     = w_ex_fs;
                C0     = w_ex_c0;
                M      = w_ex_m;
                K      = w_ex_k;
                EN_ALU = 1'b1;
                WR     = 1'b1;
                done   = 1'b1;
            end
            ST_LD_A, ST_LD_W: begin
                // RAM read data owns the D-bus, so the ALU only drives the address
                SA          = w_rn;
                DA          = w_rd;
                K           = w_off_k;
                M           = 1'b1;
                FS          = FS_ADD;
                EN_ADDR_ALU = 1'b1;
                RCS         = 1'b1;
                ROE         = 1'b1;
                WR          = (r_state == ST_LD_W);
                done        = (r_state == ST_LD_W);
            end
            ST_ST_A, ST_ST_W: begin
                // Rt travels over the B-bus onto the D-bus as write data
                SA          = w_rn;
                SB          = w_rd;
                K           = w_off_k;
                M           = 1'b1;
                FS          = FS_ADD;
                EN_ADDR_ALU = 1'b1;
                EN_B        = 1'b1;
                RCS         = 1'b1;
                RWE         = (r_state == ST_ST_W);
                done        = (r_state == ST_ST_W);
            end
            ST_ERR: begin
                err = 1'b1;
            end
            default: begin
                instr_ready = 1'b0;
            end
        endcase
    end

    // D-bus contention invariants
    a_alu_vs_b: assert property (@(posedge CLK) disable iff (!RST) !(EN_ALU && EN_B));
    a_alu_vs_ram: assert property (@(posedge CLK) disable iff (!RST) !(EN_ALU && ROE));

endmodule

// File: tb/tb_legv8_sequencer.sv
// tb_legv8_sequencer: drives legv8_sequencer with directed and random
// instructions. A small datapath (register file, ALU, RAM) obeys the DUT's
// control word. Results are checked against an architectural LEGv8 model
// that computes each instruction's effect with plain arithmetic.
module tb_legv8_sequencer;

    localparam int unsigned RAM_AW = 8;
    localparam int unsigned RAM_N  = 256;

    localparam logic [10:0] OPC_ADD  = 11'b10001011000;
    localparam logic [10:0] OPC_SUB  = 11'b11001011000;
    localparam logic [10:0] OPC_AND  = 11'b10001010000;
    localparam logic [10:0] OPC_ORR  = 11'b10101010000;
    localparam logic [10:0] OPC_ADDS = 11'b10101011000;
    localparam logic [10:0] OPC_SUBS = 11'b11101011000;
    localparam logic [10:0] OPC_LDUR = 11'b11111000010;
    localparam logic [10:0] OPC_STUR = 11'b11111000000;
    localparam logic [9:0]  OPC_ADDI = 10'b1001000100;
    localparam logic [9:0]  OPC_SUBI = 10'b1101000100;

    typedef enum int {K_ADD, K_SUB, K_AND, K_ORR, K_ADDS, K_SUBS,
                      K_ADDI, K_SUBI, K_LDUR, K_STUR, K_ILL} kind_t;

    typedef struct packed {
        logic [4:0] sa;
        logic [4:0] sb;
        logic [4:0] da;
        logic       wr;
        logic [4:0] fs;
        logic       c0;
        logic       m;
        logic       en_alu;
        logic       en_b;
        logic       en_addr;
        logic       rcs;
        logic       rwe;
        logic       roe;
        logic       done;
        logic       err;
        logic       rdy;
    } ctl_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [3:0]  stat;
    logic [4:0]  sa, sb, da, fs;
    logic        wr, c0, m, en_alu, en_b, en_addr_alu, rcs, rwe, roe, done, err;
    logic [63:0] k;
    logic [3:0]  flags;

    always #5 clk = ~clk;

    legv8_sequencer #(.RAM_AW(RAM_AW)) dut (
        .CLK(clk), .RST(rst), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .STAT(stat), .SA(sa), .SB(sb), .DA(da),
        .WR(wr), .FS(fs), .C0(c0), .K(k), .M(m), .EN_ALU(en_alu), .EN_B(en_b),
        .EN_ADDR_ALU(en_addr_alu), .RCS(rcs), .RWE(rwe), .ROE(roe),
        .flags(flags), .done(done), .err(err)
    );

    ctl_t ctl_now;
    assign ctl_now = {sa, sb, da, wr, fs, c0, m, en_alu, en_b, en_addr_alu,
                      rcs, rwe, roe, done, err, instr_ready};

    // ---------------- datapath obeying the control word ----------------
    logic [63:0] dp_regs   [32];
    logic [63:0] dp_ram    [RAM_N];
    logic [63:0] init_regs [32];
    logic        load_init;
    logic [63:0] a_bus, b_bus, op2, alu_f, d_bus;
    logic [64:0] sum65;
    logic [RAM_AW-1:0] ram_addr;
    logic        arith;

    always_comb begin
        a_bus = dp_regs[sa];
        b_bus = dp_regs[sb];
        op2   = m ? k : b_bus;
        if (fs == 5'b01010) op2 = ~op2;
        sum65 = {1'b0, a_bus} + {1'b0, op2} + 65'(c0);
        arith = (fs == 5'b01000) || (fs == 5'b01010);
        case (fs)
            5'b00000: alu_f = a_bus & op2;
            5'b00100: alu_f = a_bus | op2;
            5'b01000, 5'b01010: alu_f = sum65[63:0];
            default:  alu_f = '0;
        endcase
        stat[3] = arith && (a_bus[63] == op2[63]) && (alu_f[63] != a_bus[63]);
        stat[2] = arith && sum65[64];
        stat[1] = alu_f[63];
        stat[0] = (alu_f == 64'd0);
        ram_addr = alu_f[RAM_AW-1:0];
        d_bus = en_alu ? alu_f : en_b ? b_bus : (rcs && roe) ? dp_ram[ram_addr] : 64'd0;
    end

    always @(posedge clk) begin
        if (load_init) begin
            for (int i = 0; i < 32; i++) dp_regs[i] <= init_regs[i];
            for (int i = 0; i < RAM_N; i++) dp_ram[i] <= 64'd0;
        end else begin
            if (wr) dp_regs[da] <= d_bus;
            if (rcs && rwe) dp_ram[ram_addr] <= d_bus;
        end
    end

    // ---------------- architectural model and scoreboard ----------------
    logic [63:0] arch_regs [32];
    logic [63:0] arch_ram  [RAM_N];
    logic [3:0]  arch_flags;
    int vectors;
    int miscompares;

    function automatic kind_t classify(input logic [31:0] w);
        case (w[31:21])
            OPC_ADD:  return K_ADD;
            OPC_SUB:  return K_SUB;
            OPC_AND:  return K_AND;
            OPC_ORR:  return K_ORR;
            OPC_ADDS: return K_ADDS;
            OPC_SUBS: return K_SUBS;
            OPC_LDUR: return K_LDUR;
            OPC_STUR: return K_STUR;
            default:  ;
        endcase
        if (w[31:22] == OPC_ADDI) return K_ADDI;
        if (w[31:22] == OPC_SUBI) return K_SUBI;
        return K_ILL;
    endfunction

    function automatic logic [31:0] enc_r(input logic [10:0] op, input logic [4:0] rm,
                                          input logic [4:0] rn, input logic [4:0] rd);
        return {op, rm, 6'd0, rn, rd};
    endfunction

    function automatic logic [31:0] enc_i(input logic [9:0] op, input logic [11:0] imm,
                                          input logic [4:0] rn, input logic [4:0] rd);
        return {op, imm, rn, rd};
    endfunction

    function automatic logic [31:0] enc_d(input logic [10:0] op, input logic [8:0] off,
                                          input logic [4:0] rn, input logic [4:0] rt);
        return {op, off, 2'b00, rn, rt};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one instruction from IDLE and check every cycle until IDLE again
    task automatic run_instr(input logic [31:0] ins);
        kind_t       kd;
        logic [4:0]  rd, rn, rm;
        logic [63:0] a, b, imm, off, res, kexp;
        logic [64:0] wide;
        logic [RAM_AW-1:0] addr;
        logic [3:0]  fl;
        logic        two;
        ctl_t        e;
        int          diffs;
        kd   = classify(ins);
        rd   = ins[4:0];
        rn   = ins[9:5];
        rm   = ins[20:16];
        a    = arch_regs[rn];
        b    = arch_regs[rm];
        imm  = 64'(ins[21:10]);
        off  = {{55{ins[20]}}, ins[20:12]};
        addr = RAM_AW'(a + off);
        fl   = arch_flags;
        res  = 64'd0;
        wide = 65'd0;
        kexp = 64'd0;
        two  = (kd == K_LDUR) || (kd == K_STUR);
        case (kd)
            K_ADD, K_ADDS: begin
                res  = a + b;
                wide = {1'b0, a} + {1'b0, b};
                if (kd == K_ADDS)
                    fl = {(a[63] == b[63]) && (res[63] != a[63]), wide[64], res[63], res == 64'd0};
            end
            K_SUB, K_SUBS: begin
                res = a - b;
                if (kd == K_SUBS)
                    fl = {(a[63] != b[63]) && (res[63] != a[63]), a >= b, res[63], res == 64'd0};
            end
            K_AND:  res = a & b;
            K_ORR:  res = a | b;
            K_ADDI: begin res = a + imm; kexp = imm; end
            K_SUBI: begin res = a - imm; kexp = imm; end
            K_LDUR: begin res = arch_ram[addr]; kexp = off; end
            K_STUR: kexp = off;
            default: ;
        endcase

        check($sformatf("ready_before@%h", ins), 64'(instr_ready), 64'd1);
        instr       = ins;
        instr_valid = 1'b1;
        @(posedge clk); #1;
        // keep offering a different word while busy; it must be ignored
        instr = $urandom();

        e = '0;
        case (kd)
            K_ADD, K_ADDS, K_SUB, K_SUBS, K_AND, K_ORR, K_ADDI, K_SUBI: begin
                e.sa = rn; e.da = rd; e.wr = 1'b1; e.en_alu = 1'b1; e.done = 1'b1;
                if (kd == K_ADDI || kd == K_SUBI) e.m = 1'b1;
                else e.sb = rm;
                if (kd == K_SUB || kd == K_SUBS || kd == K_SUBI) begin
                    e.fs = 5'b01010; e.c0 = 1'b1;
                end else if (kd == K_AND) e.fs = 5'b00000;
                else if (kd == K_ORR) e.fs = 5'b00100;
                else e.fs = 5'b01000;
            end
            K_LDUR: begin
                e.sa = rn; e.da = rd; e.fs = 5'b01000; e.m = 1'b1;
                e.en_addr = 1'b1; e.rcs = 1'b1; e.roe = 1'b1;
            end
            K_STUR: begin
                e.sa = rn; e.sb = rd; e.fs = 5'b01000; e.m = 1'b1;
                e.en_addr = 1'b1; e.en_b = 1'b1; e.rcs = 1'b1;
            end
            default: e.err = 1'b1;
        endcase
        check($sformatf("cyc1_ctl@%h", ins), 64'(ctl_now), 64'(e));
        check($sformatf("cyc1_k@%h", ins), k, kexp);
        if (two) begin
            check($sformatf("cyc1_addr@%h", ins), 64'(ram_addr), 64'(addr));
            @(posedge clk); #1;
            e.done = 1'b1;
            if (kd == K_LDUR) e.wr = 1'b1;
            else e.rwe = 1'b1;
            check($sformatf("cyc2_ctl@%h", ins), 64'(ctl_now), 64'(e));
            check($sformatf("cyc2_k@%h", ins), k, kexp);
            check($sformatf("cyc2_addr@%h", ins), 64'(ram_addr), 64'(addr));
        end
        @(posedge clk); #1;
        instr_valid = 1'b0;

        // architectural effect
        if (kd == K_STUR) arch_ram[addr] = arch_regs[rd];
        else if (kd != K_ILL) arch_regs[rd] = res;
        arch_flags = fl;

        e = '0;
        e.rdy = 1'b1;
        check($sformatf("back_idle@%h", ins), 64'(ctl_now), 64'(e));
        check($sformatf("flags@%h", ins), 64'(flags), 64'(arch_flags));
        if (kd == K_STUR) begin
            check($sformatf("ram@%h", ins), dp_ram[addr], arch_ram[addr]);
        end else if (kd == K_ILL) begin
            diffs = 0;
            for (int i = 0; i < 32; i++) if (dp_regs[i] !== arch_regs[i]) diffs++;
            for (int i = 0; i < int'(RAM_N); i++) if (dp_ram[i] !== arch_ram[i]) diffs++;
            check($sformatf("ill_state_diffs@%h", ins), 64'(diffs), 64'd0);
        end else begin
            check($sformatf("rd@%h", ins), dp_regs[rd], arch_regs[rd]);
        end
    endtask

    // Watchdog: the sequence uses only fixed cycle counts, this is a backstop
    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

    initial begin
        ctl_t        e;
        logic [31:0] w;
        int unsigned sel;
        vectors     = 0;
        miscompares = 0;

        for (int i = 0; i < 32; i++) init_regs[i] = {$urandom(), $urandom()};
        init_regs[0] = 64'd0;
        init_regs[5] = 64'h0123_4567_89AB_CDEF;
        for (int i = 0; i < 32; i++) arch_regs[i] = init_regs[i];
        for (int i = 0; i < int'(RAM_N); i++) arch_ram[i] = 64'd0;
        arch_flags = 4'b0000;

        // reset with a valid instruction on the input
        rst         = 1'b0;
        load_init   = 1'b1;
        instr       = enc_i(OPC_ADDI, 12'd5, 5'd0, 5'd1);
        instr_valid = 1'b1;
        @(posedge clk); #1;
        load_init = 1'b0;
        @(posedge clk); #1;
        e = '0;
        e.rdy = 1'b1;
        check("reset_ctl", 64'(ctl_now), 64'(e));
        check("reset_k", k, 64'd0);
        check("reset_flags", 64'(flags), 64'd0);
        rst         = 1'b1;
        instr_valid = 1'b0;
        @(posedge clk); #1;
        check("post_reset_ctl", 64'(ctl_now), 64'(e));

        // ADDI X1,X0,#5
        check("addi_encoding", 64'(enc_i(OPC_ADDI, 12'd5, 5'd0, 5'd1)), 64'h9100_1401);
        run_instr(32'h9100_1401);
        check("addi_x1", dp_regs[1], 64'd5);
        // SUBS X2,X1,X1 -> zero, carry set
        run_instr(enc_r(OPC_SUBS, 5'd1, 5'd1, 5'd2));
        check("subs_x2", dp_regs[2], 64'd0);
        check("subs_flags", 64'(flags), 64'b0101);
        // ADD X4,X1,X1 leaves flags alone
        run_instr(enc_r(OPC_ADD, 5'd1, 5'd1, 5'd4));
        check("add_x4", dp_regs[4], 64'd10);
        check("add_flags_kept", 64'(flags), 64'b0101);
        // STUR X1,[X0,#8]; LDUR X3,[X0,#8]
        run_instr(enc_d(OPC_STUR, 9'd8, 5'd0, 5'd1));
        check("stur_ram8", dp_ram[8], 64'd5);
        run_instr(enc_d(OPC_LDUR, 9'd8, 5'd0, 5'd3));
        check("ldur_x3", dp_regs[3], 64'd5);
        // illegal all-ones word
        run_instr(32'hFFFF_FFFF);
        check("ill_flags_kept", 64'(flags), 64'b0101);

        // reset during LD_A of LDUR X5,[X0,#8]
        instr       = enc_d(OPC_LDUR, 9'd8, 5'd0, 5'd5);
        instr_valid = 1'b1;
        @(posedge clk); #1;
        e = '0;
        e.sa = 5'd0; e.da = 5'd5; e.fs = 5'b01000; e.m = 1'b1;
        e.en_addr = 1'b1; e.rcs = 1'b1; e.roe = 1'b1;
        check("rst_lda_ctl", 64'(ctl_now), 64'(e));
        rst         = 1'b0;
        instr_valid = 1'b0;
        @(posedge clk); #1;
        arch_flags = 4'b0000;
        e = '0;
        e.rdy = 1'b1;
        check("rst_abort_ctl", 64'(ctl_now), 64'(e));
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_abort_x5", dp_regs[5], 64'h0123_4567_89AB_CDEF);
        check("rst_abort_flags", 64'(flags), 64'd0);
        check("rst_abort_idle", 64'(ctl_now), 64'(e));
        run_instr(enc_i(OPC_ADDI, 12'd7, 5'd1, 5'd6));
        check("after_abort_x6", dp_regs[6], 64'd12);

        // randomized mix against the architectural model
        for (int n = 0; n < 300; n++) begin
            w   = $urandom();
            sel = $urandom_range(0, 10);
            case (sel)
                0: w[31:21] = OPC_ADD;
                1: w[31:21] = OPC_SUB;
                2: w[31:21] = OPC_AND;
                3: w[31:21] = OPC_ORR;
                4: w[31:21] = OPC_ADDS;
                5: w[31:21] = OPC_SUBS;
                6: w[31:22] = OPC_ADDI;
                7: w[31:22] = OPC_SUBI;
                8: w[31:21] = OPC_LDUR;
                9: w[31:21] = OPC_STUR;
                default: while (classify(w) != K_ILL) w = $urandom();
            endcase
            run_instr(w);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
